// File: rtl/cpu_pkg.sv
// Shared constants and elaboration-time helpers for the datapath blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cpu_pkg;

    // Legal range for the number of mux inputs.
    localparam int N_INPUTS_MIN = 2;
    localparam int N_INPUTS_MAX = 16;

    // Ceiling log2, used to size select buses; clog2(1) = 0, clog2(3) = 2.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry pipeline register: output register plus one skid entry, with flush.
// Latency: 1 cycle from accept to out_vld when the output register is free.
// Backpressure: in_rdy is the registered inverse of skid occupancy, no path from out_rdy.
module skid_buffer #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat
);

    logic             skid_vld;
    logic [WIDTH-1:0] skid_dat;
    logic             accept;
    logic             out_free;

    // Upstream may only push while the skid entry is empty; driven purely from state.
    assign in_rdy   = ~skid_vld;
    assign accept   = in_vld & ~skid_vld;
    // Output register can take a new word this edge: empty, or its word leaves now.
    assign out_free = ~out_vld | out_rdy;

    // Storage update: reset over flush over normal accept/transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_dat  <= '0;
            skid_vld <= 1'b0;
            skid_dat <= '0;
        end else if (flush) begin
            // Held words are dropped; the same-cycle input is ignored.
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
        end else if (out_free) begin
            if (skid_vld) begin
                // Oldest word is in skid; no accept can happen while it is full.
                out_vld  <= 1'b1;
                out_dat  <= skid_dat;
                skid_vld <= 1'b0;
            end else if (accept) begin
                out_vld <= 1'b1;
                out_dat <= in_dat;
            end else begin
                out_vld <= 1'b0;
            end
        end else if (accept) begin
            // Output stalled: park the new word behind it.
            skid_vld <= 1'b1;
            skid_dat <= in_dat;
        end
    end

endmodule

// File: rtl/pipe_mux_nto1.sv
// N-to-1 word select with out-of-range flag, registered through a 2-deep skid stage.
// Latency: 1 cycle from accept to o_valid when the output stage is free.
// Backpressure: o_ready drops once both entries hold words; o_ready never depends on i_ready.
module pipe_mux_nto1
    import cpu_pkg::*;
#(
    parameter  int NB_DATA  = 32,
    parameter  int N_INPUTS = 3,
    localparam int NB_SEL   = clog2(N_INPUTS)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [N_INPUTS*NB_DATA-1:0]  i_data,
    input  logic [NB_SEL-1:0]            i_sel,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic                         i_flush,
    output logic [NB_DATA-1:0]           o_data,
    output logic                         o_sel_err,
    output logic                         o_valid,
    input  logic                         i_ready
);

    // Reject unsupported input counts at elaboration.
    if (N_INPUTS < N_INPUTS_MIN || N_INPUTS > N_INPUTS_MAX) begin : g_bad_n_inputs
        $error("pipe_mux_nto1: N_INPUTS out of supported range");
    end

    logic [NB_DATA-1:0] sel_dat;
    logic               sel_err;

    // Select decode: matching input wins; an unmatched select yields zero with the error flag.
    always_comb begin
        sel_dat = '0;
        sel_err = 1'b1;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (i_sel == NB_SEL'(k)) begin
                sel_dat = i_data[k*NB_DATA +: NB_DATA];
                sel_err = 1'b0;
            end
        end
    end

    // Error flag travels as the MSB alongside its word through both storage entries.
    skid_buffer #(
        .WIDTH (NB_DATA + 1)
    ) u_skid_buffer (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .flush   (i_flush),
        .in_vld  (i_valid),
        .in_rdy  (o_ready),
        .in_dat  ({sel_err, sel_dat}),
        .out_vld (o_valid),
        .out_rdy (i_ready),
        .out_dat ({o_sel_err, o_data})
    );

endmodule

// File: tb/tb_pipe_mux_nto1.sv
module tb_pipe_mux_nto1;

    localparam int NB_DATA  = 32;
    localparam int N_INPUTS = 3;
    localparam int NB_SEL   = 2;

    logic                        i_clk = 1'b0;
    logic                        i_rst_n;
    logic [N_INPUTS*NB_DATA-1:0] i_data;
    logic [NB_SEL-1:0]           i_sel;
    logic                        i_valid;
    logic                        o_ready;
    logic                        i_flush;
    logic [NB_DATA-1:0]          o_data;
    logic                        o_sel_err;
    logic                        o_valid;
    logic                        i_ready;

    logic [NB_DATA-1:0] din [N_INPUTS];

    assign i_data = {din[2], din[1], din[0]};

    always #5 i_clk = ~i_clk;

    pipe_mux_nto1 #(
        .NB_DATA  (NB_DATA),
        .N_INPUTS (N_INPUTS)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_data    (i_data),
        .i_sel     (i_sel),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_flush   (i_flush),
        .o_data    (o_data),
        .o_sel_err (o_sel_err),
        .o_valid   (o_valid),
        .i_ready   (i_ready)
    );

    // Reference: the words the block currently holds, oldest first, as {sel_err, data}.
    logic [NB_DATA:0] exp_q [$];
    bit               zero_expected = 1'b1;
    bit               mon_en        = 1'b0;
    int               n_checks      = 0;
    int               n_pass        = 0;
    int               n_accepted    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply the rules for the inputs the DUT sampled at this rising edge.
    function automatic void model_update();
        bit               can_accept;
        logic [NB_DATA:0] w;
        can_accept = (exp_q.size() < 2);
        if (!i_rst_n) begin
            exp_q.delete();
            zero_expected = 1'b1;
        end else if (i_flush) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0 && i_ready) begin
                void'(exp_q.pop_front());
            end
            if (i_valid && can_accept) begin
                if (int'(i_sel) < N_INPUTS) begin
                    w = {1'b0, din[i_sel]};
                end else begin
                    w = {1'b1, {NB_DATA{1'b0}}};
                end
                exp_q.push_back(w);
                n_accepted++;
                zero_expected = 1'b0;
            end
        end
    endfunction

    // Monitor: compare DUT outputs with the reference mid-cycle.
    initial begin
        forever begin
            @(negedge i_clk);
            if (mon_en) begin
                check("o_valid", 64'(o_valid), 64'(exp_q.size() > 0));
                check("o_ready", 64'(o_ready), 64'(exp_q.size() < 2));
                if (exp_q.size() > 0) begin
                    check("o_data", 64'(o_data), 64'(exp_q[0][NB_DATA-1:0]));
                    check("o_sel_err", 64'(o_sel_err), 64'(exp_q[0][NB_DATA]));
                end else if (zero_expected) begin
                    check("o_data_reset", 64'(o_data), 64'd0);
                    check("o_sel_err_reset", 64'(o_sel_err), 64'd0);
                end
            end
        end
    end

    task automatic step(input bit rst_n, input bit vld, input int sel,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input bit flush, input bit rdy);
        @(posedge i_clk);
        model_update();
        #1;
        i_rst_n = rst_n;
        i_valid = vld;
        i_sel   = sel[1:0];
        din[0]  = a;
        din[1]  = b;
        din[2]  = c;
        i_flush = flush;
        i_ready = rdy;
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 0, 32'h0, 32'h0, 32'h0, 1'b0, rdy);
        end
    endtask

    initial begin
        int start_cnt;
        i_rst_n = 1'b0;
        i_valid = 1'b1;
        i_sel   = '0;
        din[0]  = 32'hDEAD;
        din[1]  = 32'hBEEF;
        din[2]  = 32'hCAFE;
        i_flush = 1'b0;
        i_ready = 1'b0;

        // Reset with valid asserted: must be ignored.
        step(1'b0, 1'b1, 0, 32'hDEAD, 32'hBEEF, 32'hCAFE, 1'b0, 1'b0);
        mon_en = 1'b1;
        step(1'b1, 1'b0, 0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

        // In-range select, then out-of-range select.
        step(1'b1, 1'b1, 2, 32'h11, 32'h22, 32'h33, 1'b0, 1'b1);
        step(1'b1, 1'b1, 3, 32'h11, 32'h22, 32'h33, 1'b0, 1'b1);
        idle(1'b1, 2);

        // Stall: 0xA then 0xB held, a third word refused, then drain in order.
        step(1'b1, 1'b1, 0, 32'hA, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 0, 32'hB, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1, 32'h0, 32'hD, 32'h0, 1'b0, 1'b0);
        idle(1'b0, 2);
        idle(1'b1, 3);

        // Flush with skid full and a same-cycle word 0xC.
        step(1'b1, 1'b1, 1, 32'h0, 32'h1, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1, 32'h0, 32'h2, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1, 32'h0, 32'hC, 32'h0, 1'b1, 1'b1);
        idle(1'b1, 3);

        // Reset for one cycle with skid full.
        step(1'b1, 1'b1, 2, 32'h0, 32'h0, 32'h5, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2, 32'h0, 32'h0, 32'h6, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2, 32'h0, 32'h0, 32'h7, 1'b0, 1'b1);
        idle(1'b1, 3);

        // Random stream of at least 100 accepted words with random backpressure.
        start_cnt = n_accepted;
        for (int cyc = 0; cyc < 3000 && (n_accepted - start_cnt) < 100; cyc++) begin
            step(1'b1, $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                 $urandom, $urandom, $urandom, 1'b0, $urandom_range(0, 1) == 1);
        end
        idle(1'b1, 1);
        check("stream_100_accepted", 64'((n_accepted - start_cnt) >= 100), 64'd1);

        // Random traffic with occasional flush and reset.
        for (int cyc = 0; cyc < 300; cyc++) begin
            step($urandom_range(0, 40) != 0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                 $urandom, $urandom, $urandom, $urandom_range(0, 25) == 0,
                 $urandom_range(0, 2) != 0);
        end

        // Drain everything.
        idle(1'b1, 4);
        @(negedge i_clk);
        #1;
        check("final_empty", 64'(o_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
